// File: rtl/cpc_bootdata_streamer.sv
// ---------------------------------------------------------------------------
// cpc_bootdata_streamer
//
// Host-side sender for the CPC ROM-load port. It takes the image byte stream
// coming from the board loader (SD/SPI reader), packs the bytes
// little-endian into 32-bit words and hands each word to the memory
// subsystem with a 4-phase req/ack handshake on host_bootdata_*. Bytes are
// counted against the expected image size. The block reports done when the
// whole image has been delivered, or a sticky error if the receiver stalls
// a handshake phase for too long.
//
// Parameters
//   TOTAL_BYTES  image size in bytes (1 .. 2^20)
//   TIMEOUT      ck16 cycles allowed per handshake phase; 0 = no timeout
//   PAD_BYTE     fill value for the unused lanes of a final partial word
//
// Ports
//   ck16               16 MHz system clock
//   reset              asynchronous, active-high reset
//   start              single-cycle pulse, begins a transfer when not busy
//   byte_data          next image byte
//   byte_valid         byte_data is valid
//   byte_ready         byte accepted this cycle when byte_valid is also high
//   host_bootdata      packed word, first byte of the word in [7:0]
//   host_bootdata_req  word valid request to the receiver
//   host_bootdata_ack  receiver acknowledge
//   busy               transfer in progress
//   done               sticky, image fully transferred
//   error              sticky, handshake timeout
//   byte_count         bytes accepted since start
// ---------------------------------------------------------------------------
module cpc_bootdata_streamer #(
   parameter int unsigned TOTAL_BYTES = 49152,
   parameter int unsigned TIMEOUT     = 16777215,
   parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
   input  logic        ck16,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] host_bootdata,
   output logic        host_bootdata_req,
   input  logic        host_bootdata_ack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [19:0] byte_count
);

   // The counter is one bit wider than the port so that an image of exactly
   // 2^20 bytes can still be compared against its size; the port shows the
   // low 20 bits.
   localparam logic [20:0] TOTAL_CNT    = 21'(TOTAL_BYTES);
   localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
   localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_EN ? 24'(TIMEOUT - 1) : 24'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PACK,
      ST_REQ,
      ST_RELEASE,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t      state;
   logic [2:0]  lane;
   logic [20:0] count_q;
   logic [23:0] timer;

   logic [20:0] count_inc;
   logic        last_byte;
   logic        word_full;
   logic        accept;
   logic        timer_expired;
   logic [31:0] packed_word;

   assign byte_count = count_q[19:0];

   // Next-word builder. The incoming byte lands in the current lane; when it
   // is the last byte of the image the lanes above it are filled with the pad
   // value so a partial final word never carries stale bytes of the previous
   // word. The timer expires on the edge where it has already waited
   // TIMEOUT-1 cycles, so the error lands exactly TIMEOUT cycles after entry.
   always_comb begin
      count_inc     = count_q + 21'd1;
      last_byte     = (count_inc == TOTAL_CNT);
      word_full     = (lane == 3'd3);
      accept        = (state == ST_PACK) && byte_ready && byte_valid;
      timer_expired = TIMEOUT_EN && (timer == TIMEOUT_LAST);
      packed_word   = host_bootdata;
      for (int i = 0; i < 4; i++) begin
         if (lane == 3'(i)) begin
            packed_word[8*i +: 8] = byte_data;
         end else if (last_byte && (3'(i) > lane)) begin
            packed_word[8*i +: 8] = PAD_BYTE;
         end
      end
   end

   // Main control FSM with all outputs registered.
   // PACK: accept up to four bytes; the edge that takes the last byte of a
   // word moves to REQ and drops byte_ready, raising req on that same edge
   // unless the receiver still holds ack from an earlier word.
   // REQ: hold the word stable, raise req only once ack is low, and drop req
   // on the edge that sees ack.
   // RELEASE: wait for ack to fall, then either finish or pack the next word.
   // Only the two handshake waits are bounded by the timer; PACK can wait on
   // the loader forever.
   always_ff @(posedge ck16 or posedge reset) begin
      if (reset) begin
         state             <= ST_IDLE;
         host_bootdata     <= 32'h0;
         host_bootdata_req <= 1'b0;
         byte_ready        <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         count_q           <= 21'd0;
         lane              <= 3'd0;
         timer             <= 24'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state      <= ST_PACK;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  count_q    <= 21'd0;
                  lane       <= 3'd0;
                  timer      <= 24'd0;
                  byte_ready <= 1'b1;
               end
            end

            ST_PACK: begin
               if (accept) begin
                  host_bootdata <= packed_word;
                  count_q       <= count_inc;
                  lane          <= lane + 3'd1;
                  if (word_full || last_byte) begin
                     state             <= ST_REQ;
                     byte_ready        <= 1'b0;
                     timer             <= 24'd0;
                     host_bootdata_req <= ~host_bootdata_ack;
                  end
               end
            end

            ST_REQ: begin
               if (host_bootdata_req && host_bootdata_ack) begin
                  state             <= ST_RELEASE;
                  host_bootdata_req <= 1'b0;
                  timer             <= 24'd0;
               end else if (timer_expired) begin
                  state             <= ST_ERR;
                  host_bootdata_req <= 1'b0;
                  error             <= 1'b1;
                  busy              <= 1'b0;
               end else begin
                  timer <= timer + 24'd1;
                  if (!host_bootdata_ack) begin
                     host_bootdata_req <= 1'b1;
                  end
               end
            end

            ST_RELEASE: begin
               if (!host_bootdata_ack) begin
                  timer <= 24'd0;
                  if (count_q == TOTAL_CNT) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state      <= ST_PACK;
                     lane       <= 3'd0;
                     byte_ready <= 1'b1;
                  end
               end else if (timer_expired) begin
                  state <= ST_ERR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer + 24'd1;
               end
            end

            default: begin
               state             <= ST_IDLE;
               host_bootdata_req <= 1'b0;
               byte_ready        <= 1'b0;
               busy              <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpc_bootdata_streamer.sv
// ---------------------------------------------------------------------------
// tb_cpc_bootdata_streamer
//
// Two streamers share the clock: one sized for an 8-byte image with a
// 100-cycle handshake timeout, one for a 6-byte image. 'sel' routes the
// stimulus to one of them and picks which one's outputs are observed.
// Expected words are queued when a transfer is launched and popped by the
// monitor whenever req rises.
// ---------------------------------------------------------------------------
module tb_cpc_bootdata_streamer;

   typedef struct {
      int          sel;
      int          nbytes;
      int          gap;
      int          ack_dly;
      int          rel_dly;
      logic [63:0] bytes;
      int          nwords;
      logic [63:0] words;
      int          exp_count;
   } vec_t;

   logic        ck16;
   logic        reset;
   logic        start;
   logic        sel;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        ack;
   logic        ack_auto;
   int          ack_dly;
   int          rel_dly;

   int          checks;
   int          passed;
   int          req_pulses;
   int          stab_err;
   int          brdy_err;
   logic [31:0] exp_q[$];
   vec_t        vecs[5];

   logic        start8, valid8, ack8, ready8, req8, busy8, done8, err8;
   logic [31:0] data8;
   logic [19:0] cnt8;
   logic        start6, valid6, ack6, ready6, req6, busy6, done6, err6;
   logic [31:0] data6;
   logic [19:0] cnt6;

   logic        cur_req, cur_byte_ready, cur_busy, cur_done, cur_error;
   logic [31:0] cur_data;
   logic [19:0] cur_count;

   assign start8 = start & ~sel;
   assign valid8 = byte_valid & ~sel;
   assign ack8   = ack & ~sel;
   assign start6 = start & sel;
   assign valid6 = byte_valid & sel;
   assign ack6   = ack & sel;

   assign cur_req        = sel ? req6 : req8;
   assign cur_byte_ready = sel ? ready6 : ready8;
   assign cur_busy       = sel ? busy6 : busy8;
   assign cur_done       = sel ? done6 : done8;
   assign cur_error      = sel ? err6 : err8;
   assign cur_data       = sel ? data6 : data8;
   assign cur_count      = sel ? cnt6 : cnt8;

   cpc_bootdata_streamer #(
      .TOTAL_BYTES(8),
      .TIMEOUT(100),
      .PAD_BYTE(8'hFF)
   ) dut8 (
      .ck16(ck16),
      .reset(reset),
      .start(start8),
      .byte_data(byte_data),
      .byte_valid(valid8),
      .byte_ready(ready8),
      .host_bootdata(data8),
      .host_bootdata_req(req8),
      .host_bootdata_ack(ack8),
      .busy(busy8),
      .done(done8),
      .error(err8),
      .byte_count(cnt8)
   );

   cpc_bootdata_streamer #(
      .TOTAL_BYTES(6),
      .TIMEOUT(1000),
      .PAD_BYTE(8'hFF)
   ) dut6 (
      .ck16(ck16),
      .reset(reset),
      .start(start6),
      .byte_data(byte_data),
      .byte_valid(valid6),
      .byte_ready(ready6),
      .host_bootdata(data6),
      .host_bootdata_req(req6),
      .host_bootdata_ack(ack6),
      .busy(busy6),
      .done(done6),
      .error(err6),
      .byte_count(cnt6)
   );

   // 16 MHz-style free-running clock, 10 time units per period.
   initial begin
      ck16 = 1'b0;
      forever #5 ck16 = ~ck16;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Scoreboard side: every req rising edge must present the next queued
   // word, and the word must stay put while req is high.
   task automatic monitor();
      logic        prev_req;
      logic [31:0] held;
      logic [31:0] exp_word;
      prev_req = 1'b0;
      held     = 32'h0;
      forever begin
         @(negedge ck16);
         if (cur_req && !prev_req) begin
            req_pulses++;
            held = cur_data;
            if (exp_q.size() == 0) begin
               checks++;
               $display("[TB] FAIL word_unexpected: got %h, expected no request", cur_data);
            end else begin
               exp_word = exp_q.pop_front();
               checkOutput("word", cur_data, exp_word);
            end
         end else if (cur_req && (cur_data !== held)) begin
            stab_err++;
         end
         if ((cur_req || ack) && cur_byte_ready) begin
            brdy_err++;
         end
         prev_req = cur_req;
      end
   endtask

   // Receiver model: ack ack_dly cycles after req is seen, release rel_dly
   // cycles after req falls.
   task automatic responder();
      forever begin
         @(negedge ck16);
         if (ack_auto && cur_req && !ack) begin
            repeat (ack_dly) @(negedge ck16);
            ack = 1'b1;
            while (cur_req) @(negedge ck16);
            repeat (rel_dly) @(negedge ck16);
            ack = 1'b0;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         @(negedge ck16);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!cur_byte_ready && n < 1000) begin
         @(negedge ck16);
         n++;
      end
      if (!cur_byte_ready) begin
         checks++;
         $display("[TB] FAIL byte_accept: byte %h still waiting after %0d cycles, expected acceptance", b, n);
      end else begin
         @(negedge ck16);
      end
   endtask

   task automatic wait_for_done(input string name);
      int n;
      n = 0;
      while (!cur_done && n < 3000) begin
         @(negedge ck16);
         n++;
      end
      if (!cur_done) begin
         checks++;
         $display("[TB] FAIL %s: done still 0 after %0d cycles, expected 1", name, n);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge ck16);
      start = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      sel      = v.sel[0];
      ack_dly  = v.ack_dly;
      rel_dly  = v.rel_dly;
      ack      = 1'b0;
      ack_auto = 1'b1;
      @(negedge ck16);
      req_pulses = 0;
      stab_err   = 0;
      brdy_err   = 0;
      for (int w = 0; w < v.nwords; w++) begin
         exp_q.push_back(v.words[32*w +: 32]);
      end
      pulse_start();
      checkOutput("busy_after_start", 32'(cur_busy), 32'd1);
      checkOutput("error_after_start", 32'(cur_error), 32'd0);
      for (int i = 0; i < v.nbytes; i++) begin
         send_byte(v.bytes[8*i +: 8], v.gap);
      end
      byte_valid = 1'b0;
      checkOutput("req_latency", 32'(cur_req), 32'd1);
      wait_for_done("vec_done");
      checkOutput("done", 32'(cur_done), 32'd1);
      checkOutput("busy_at_done", 32'(cur_busy), 32'd0);
      checkOutput("error_at_done", 32'(cur_error), 32'd0);
      checkOutput("byte_count", 32'(cur_count), 32'(v.exp_count));
      checkOutput("req_pulses", 32'(req_pulses), 32'(v.nwords));
      checkOutput("words_left", 32'(exp_q.size()), 32'd0);
      checkOutput("data_stable", 32'(stab_err), 32'd0);
      checkOutput("ready_in_handshake", 32'(brdy_err), 32'd0);
      // Extra bytes after the image must be refused.
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      repeat (3) @(negedge ck16);
      checkOutput("ready_after_done", 32'(cur_byte_ready), 32'd0);
      checkOutput("count_saturated", 32'(cur_count), 32'(v.exp_count));
      byte_valid = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int n;
      checks     = 0;
      passed     = 0;
      req_pulses = 0;
      stab_err   = 0;
      brdy_err   = 0;
      reset      = 1'b1;
      start      = 1'b0;
      sel        = 1'b0;
      byte_data  = 8'h00;
      byte_valid = 1'b0;
      ack        = 1'b0;
      ack_auto   = 1'b0;
      ack_dly    = 2;
      rel_dly    = 2;

      vecs[0] = '{sel: 0, nbytes: 8, gap: 0, ack_dly: 2, rel_dly: 2,
                  bytes: 64'h0807060504030201, nwords: 2,
                  words: 64'h08070605_04030201, exp_count: 8};
      vecs[1] = '{sel: 1, nbytes: 6, gap: 0, ack_dly: 2, rel_dly: 2,
                  bytes: 64'h0000FFEEDDCCBBAA, nwords: 2,
                  words: 64'hFFFFFFEE_DDCCBBAA, exp_count: 6};
      vecs[2] = '{sel: 0, nbytes: 8, gap: 2, ack_dly: 50, rel_dly: 2,
                  bytes: 64'h0807060504030201, nwords: 2,
                  words: 64'h08070605_04030201, exp_count: 8};
      vecs[3] = '{sel: 0, nbytes: 8, gap: 1, ack_dly: 1, rel_dly: 1,
                  bytes: 64'h8877665544332211, nwords: 2,
                  words: 64'h88776655_44332211, exp_count: 8};
      vecs[4] = '{sel: 1, nbytes: 6, gap: 1, ack_dly: 3, rel_dly: 0,
                  bytes: 64'h0000605040302010, nwords: 2,
                  words: 64'hFFFF6050_40302010, exp_count: 6};

      fork
         monitor();
         responder();
      join_none

      repeat (2) @(negedge ck16);
      checkOutput("rst_req", 32'(req8), 32'd0);
      checkOutput("rst_data", data8, 32'h0);
      checkOutput("rst_ready", 32'(ready8), 32'd0);
      checkOutput("rst_busy", 32'(busy8), 32'd0);
      checkOutput("rst_done", 32'(done8), 32'd0);
      checkOutput("rst_error", 32'(err8), 32'd0);
      checkOutput("rst_count", 32'(cnt8), 32'd0);
      checkOutput("rst_req6", 32'(req6), 32'd0);
      reset = 1'b0;
      @(negedge ck16);
      // Stray valid and ack while idle must not move anything.
      byte_valid = 1'b1;
      ack        = 1'b1;
      repeat (3) @(negedge ck16);
      checkOutput("idle_ready", 32'(ready8), 32'd0);
      checkOutput("idle_count", 32'(cnt8), 32'd0);
      byte_valid = 1'b0;
      ack        = 1'b0;

      for (int i = 0; i < 5; i++) begin
         $display("[TB] vector %0d", i);
         applyStimulus(vecs[i]);
      end

      // Receiver never acknowledges: error exactly 100 cycles after req.
      $display("[TB] timeout sequence");
      sel      = 1'b0;
      ack_auto = 1'b0;
      ack      = 1'b0;
      @(negedge ck16);
      exp_q.push_back(32'h04030201);
      pulse_start();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      byte_valid = 1'b0;
      checkOutput("to_req_high", 32'(cur_req), 32'd1);
      n = 0;
      while (!cur_error && n < 300) begin
         @(negedge ck16);
         n++;
      end
      checkOutput("to_cycles", 32'(n), 32'd100);
      checkOutput("to_error", 32'(cur_error), 32'd1);
      checkOutput("to_req_low", 32'(cur_req), 32'd0);
      checkOutput("to_busy", 32'(cur_busy), 32'd0);
      checkOutput("to_ready", 32'(cur_byte_ready), 32'd0);
      applyStimulus(vecs[0]);

      // Asynchronous reset while a word is being requested.
      $display("[TB] reset sequence");
      ack_auto = 1'b0;
      ack      = 1'b0;
      @(negedge ck16);
      exp_q.push_back(32'h04030201);
      pulse_start();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      byte_valid = 1'b0;
      repeat (2) @(negedge ck16);
      checkOutput("mid_req_req", 32'(cur_req), 32'd1);
      checkOutput("mid_req_count", 32'(cur_count), 32'd4);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_req", 32'(cur_req), 32'd0);
      checkOutput("async_rst_count", 32'(cur_count), 32'd0);
      checkOutput("async_rst_busy", 32'(cur_busy), 32'd0);
      #1 reset = 1'b0;
      @(negedge ck16);
      applyStimulus(vecs[0]);

      // ack still high when the first word is ready.
      $display("[TB] ack-high sequence");
      sel      = 1'b0;
      ack_auto = 1'b0;
      ack      = 1'b1;
      @(negedge ck16);
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      pulse_start();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      byte_valid = 1'b0;
      checkOutput("ackhigh_req_held", 32'(cur_req), 32'd0);
      repeat (3) @(negedge ck16);
      checkOutput("ackhigh_req_still_held", 32'(cur_req), 32'd0);
      ack = 1'b0;
      @(negedge ck16);
      checkOutput("ackhigh_req_rise", 32'(cur_req), 32'd1);
      @(negedge ck16);
      ack = 1'b1;
      n = 0;
      while (cur_req && n < 100) begin
         @(negedge ck16);
         n++;
      end
      checkOutput("ackhigh_req_drop", 32'(cur_req), 32'd0);
      ack      = 1'b0;
      ack_dly  = 2;
      rel_dly  = 1;
      ack_auto = 1'b1;
      for (int i = 5; i <= 8; i++) send_byte(8'(i), 0);
      byte_valid = 1'b0;
      wait_for_done("ackhigh_done");
      checkOutput("ackhigh_done", 32'(cur_done), 32'd1);
      checkOutput("ackhigh_count", 32'(cur_count), 32'd8);
      checkOutput("ackhigh_words_left", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cpc_bootdata_streamer.md
Name: cpc_bootdata_streamer

Overview:
- Host-side sender for the CPC ROM-load port: drives host_bootdata / host_bootdata_req and consumes host_bootdata_ack, the port the memory subsystem receives on.
- Takes a byte stream (valid/ready) from the loader (SD/SPI reader), packs bytes little-endian into 32-bit words and transfers each word with a 4-phase req/ack handshake.
- Counts bytes against the expected image size and flags done or a timeout error.
- Sits between the board-level loader and the cpc core's host_bootdata_* ports.

Parameters:
TOTAL_BYTES, 49152, image size in bytes (OS+BASIC+AMSDOS); 1..2^20
TIMEOUT, 16777215, ck16 cycles allowed per handshake phase before error; 0 disables the timeout
PAD_BYTE, 8'hFF, fill value for unused lanes of a final partial word

Ports:
ck16  in  1  system clock, 16 MHz
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a transfer when idle
byte_data  in  8  next image byte
byte_valid  in  1  byte_data is valid
byte_ready  out  1  block accepts byte_data this cycle (transfer when valid&ready)
host_bootdata  out  32  packed word, little-endian (first byte in [7:0])
host_bootdata_req  out  1  word valid request
host_bootdata_ack  in  1  receiver acknowledge
busy  out  1  transfer in progress
done  out  1  sticky; image fully transferred
error  out  1  sticky; handshake timeout
byte_count  out  20  bytes accepted since start

Behaviour:
- Reset (async, any state): state=IDLE; host_bootdata=32'h0, req=0, byte_ready=0, busy=0, done=0, error=0, byte_count=0, lane=0, timer=0.
- States: IDLE, PACK, REQ, RELEASE, DONE, ERR.
- IDLE:
  - start=1 -> PACK, busy=1, clear done/error/byte_count/lane.
  - start is ignored in any other state.
- PACK:
  - byte_ready=1.
  - On valid&ready: write byte into lane [8*lane+7:8*lane], lane++, byte_count++.
  - When lane reaches 4 or byte_count reaches TOTAL_BYTES -> REQ in the next cycle.
  - Unfilled upper lanes are set to PAD_BYTE.
  - byte_ready drops the cycle after the final byte of a word is accepted; never more than 4 bytes per word.
- REQ:
  - req=1, host_bootdata held stable, byte_ready=0.
  - ack=1 -> RELEASE with req=0 registered on the same edge.
- RELEASE:
  - req=0; wait for ack=0.
  - Then: if byte_count==TOTAL_BYTES -> DONE, else PACK with lane=0.
- Handshake ordering:
  - req never rises while ack=1. If entering REQ with ack still high, req stays 0 until ack=0.
  - Data changes only while req=0 and ack=0.
- Latency:
  - Last byte accepted -> req high: 1 cycle.
  - ack high -> req low: 1 cycle.
  - ack low -> byte_ready high: 1 cycle.
- DONE:
  - done=1, busy=0, req=0, byte_ready=0.
  - start -> new transfer as from IDLE.
- Timeout:
  - timer clears on each entry to REQ or RELEASE and counts while waiting.
  - Reaching TIMEOUT (if nonzero) -> ERR.
  - ERR: error=1, busy=0, req=0, byte_ready=0. start restarts as from IDLE.
  - PACK waits indefinitely; no timeout applies.
- byte_count saturates at TOTAL_BYTES. Bytes offered after that are not accepted (byte_ready=0).
- ack pulses outside REQ/RELEASE are ignored.
- byte_valid asserted in IDLE/DONE/ERR is ignored.

Test Plan:
- TOTAL_BYTES=8; bytes 01..08 with valid held high; ack responds 2 cycles after req, drops 2 cycles after req falls -> words 32'h04030201 then 32'h08070605, done=1, byte_count=8, exactly 2 req pulses.
- TOTAL_BYTES=6; bytes AA,BB,CC,DD,EE,FF -> second word 32'hFFFFFFEE (PAD_BYTE=FF), done=1.
- Gappy byte_valid (valid 1 of every 3 cycles) plus ack delayed 50 cycles -> same words as the first case; host_bootdata never changes while req=1; byte_ready=0 throughout REQ/RELEASE.
- TIMEOUT=100; never assert ack -> error=1 exactly 100 cycles after req rises; req=0, busy=0; then start -> clean restart, error cleared.
- Reset pulsed mid-REQ (req=1, byte_count=4) -> asynchronously req=0, byte_count=0, busy=0; a subsequent start yields a full correct transfer.
- ack already high at entry to REQ -> req stays 0 until ack falls, then rises the next cycle.
